// File: rtl/out_drain_encoder.sv
// rtl/out_drain_encoder.sv - drains the accumulator buffer, requantizes to int8 with optional ReLU,
// and re-encodes each BUS_SIZE group as a sparse map plus compacted non-zero bytes.
module out_drain_encoder #(
   parameter int OUTPUT_BUF_SIZE = 32,
   parameter int OUTPUT_BUF_NUM  = 32,
   parameter int BUS_SIZE        = 8
) (
   input  logic                                        clk_i,
   input  logic                                        rst_i,
   input  logic                                        start_i,
   input  logic [4:0]                                  shift_i,
   input  logic                                        relu_en_i,
   output logic                                        busy_o,
   output logic                                        done_o,
   output logic [$clog2(OUTPUT_BUF_NUM)-1:0]           out_buf_sel_o,
   input  logic [OUTPUT_BUF_SIZE-1:0]                  out_buf_dat_i,
   output logic [BUS_SIZE-1:0]                         enc_sparsemap_o,
   output logic [BUS_SIZE*8-1:0]                       enc_nonzero_data_o,
   output logic                                        enc_wr_valid_o,
   output logic [$clog2(OUTPUT_BUF_NUM/BUS_SIZE)-1:0]  enc_wr_count_o,
   input  logic                                        enc_ready_i
);

   localparam int SW     = $clog2(OUTPUT_BUF_NUM);
   localparam int GROUPS = OUTPUT_BUF_NUM / BUS_SIZE;
   localparam int CW     = $clog2(GROUPS);
   localparam int LW     = $clog2(BUS_SIZE);
   localparam int AW     = OUTPUT_BUF_SIZE + 1;
   localparam logic signed [AW-1:0] QMAX = 127;
   localparam logic signed [AW-1:0] QMIN = -128;

   typedef enum logic [1:0] {IDLE, READ, EMIT, DONE} state_t;

   state_t                state, state_next;
   logic [4:0]            shift_q;
   logic                  relu_q;
   logic [CW-1:0]         group;
   logic [LW-1:0]         lane;
   logic [LW-1:0]         ptr;
   logic [BUS_SIZE-1:0]   map;
   logic [BUS_SIZE*8-1:0] data;

   logic signed [AW-1:0]  wide, rounded, shifted;
   logic [AW-1:0]         half;
   logic [7:0]            q;
   logic                  last_lane, last_group;

   assign last_lane  = (lane == LW'(BUS_SIZE - 1));
   assign last_group = (group == CW'(GROUPS - 1));

   // Rounding add is one bit wider than the accumulator so it can never wrap.
   always_comb begin
      wide    = {out_buf_dat_i[OUTPUT_BUF_SIZE-1], out_buf_dat_i};
      half    = '0;
      if (shift_q != 5'd0)
         half = AW'(1) << (shift_q - 5'd1);
      rounded = wide + $signed(half);
      shifted = rounded >>> shift_q;
      if (shifted > QMAX)
         q = 8'h7f;
      else if (shifted < QMIN)
         q = 8'h80;
      else
         q = shifted[7:0];
      if (relu_q && q[7])
         q = 8'h00;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (start_i) state_next = READ;
         READ: if (last_lane) state_next = EMIT;
         EMIT: if (enc_ready_i) state_next = last_group ? DONE : READ;
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy_o         = (state == READ) || (state == EMIT);
      enc_wr_valid_o = (state == EMIT);
      done_o         = (state == DONE);
      out_buf_sel_o  = '0;
      if (state == READ)
         out_buf_sel_o = SW'(group) * SW'(BUS_SIZE) + SW'(lane);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         shift_q <= '0;
         relu_q  <= 1'b0;
         group   <= '0;
         lane    <= '0;
         ptr     <= '0;
         map     <= '0;
         data    <= '0;
      end else begin
         case (state)
            IDLE: if (start_i) begin
               shift_q <= shift_i;
               relu_q  <= relu_en_i;
               group   <= '0;
               lane    <= '0;
               ptr     <= '0;
               map     <= '0;
               data    <= '0;
            end
            READ: begin
               if (q != 8'h00) begin
                  map[lane]         <= 1'b1;
                  data[ptr*8 +: 8]  <= q;
                  ptr               <= ptr + 1'b1;
               end
               lane <= last_lane ? '0 : lane + 1'b1;
            end
            // Slots above the final pointer must read 0, so the whole beat is cleared per group.
            EMIT: if (enc_ready_i && !last_group) begin
               group <= group + 1'b1;
               lane  <= '0;
               ptr   <= '0;
               map   <= '0;
               data  <= '0;
            end
            default: ;
         endcase
      end
   end

   assign enc_sparsemap_o    = map;
   assign enc_nonzero_data_o = data;
   assign enc_wr_count_o     = group;

endmodule

// File: doc/out_drain_encoder.md
# out_drain_encoder

Drains the accumulator output buffer of the compute unit after a layer pass, requantizes each 32-bit partial sum to int8 with optional ReLU, and re-encodes the results into sparse-map + compacted non-zero beats for the next layer. It sits directly downstream of the compute unit top: it drives that block's `out_buf_sel_i` and consumes `out_buf_dat_o`. It emits BUS_SIZE-entry chunks in the same sparse-map/nonzero/count format that the compute unit's IFM/filter write ports accept.

## Interface
Parameters:
- OUTPUT_BUF_SIZE, 32, accumulator width in bits, signed two's complement
- OUTPUT_BUF_NUM, 32, number of accumulator entries; must be a multiple of BUS_SIZE
- BUS_SIZE, 8, entries per emitted beat

Ports:
- clk_i  input  1  clock; all logic on rising edge
- rst_i  input  1  reset, synchronous, active-low
- start_i  input  1  drain request pulse; accepted only in IDLE
- shift_i  input  5  right-shift amount; sampled on accepted start
- relu_en_i  input  1  ReLU enable; sampled on accepted start
- busy_o  output  1  high in READ and EMIT
- done_o  output  1  one-cycle pulse after the final beat handshake
- out_buf_sel_o  output  $clog2(OUTPUT_BUF_NUM)  output buffer entry index
- out_buf_dat_i  input  OUTPUT_BUF_SIZE  entry data; combinational from out_buf_sel_o, same cycle
- enc_sparsemap_o  output  BUS_SIZE  bit i set when lane i result is non-zero
- enc_nonzero_data_o  output  BUS_SIZE x 8  compacted non-zero int8 values
- enc_wr_valid_o  output  1  beat valid
- enc_wr_count_o  output  $clog2(OUTPUT_BUF_NUM/BUS_SIZE)  beat index within the drain
- enc_ready_i  input  1  consumer accepts the beat when valid and ready are both high

## Operation
- FSM states and transitions:
  - IDLE -> READ on start_i. Latch shift_i and relu_en_i. Clear group index, lane index, pack pointer and sparse map.
  - READ: one entry per cycle. out_buf_sel_o = group*BUS_SIZE + lane. After lane BUS_SIZE-1 -> EMIT.
  - EMIT: hold enc_wr_valid_o high until enc_ready_i. On handshake: last group -> DONE, otherwise group+1, lanes, pointer and map cleared, -> READ.
  - DONE: done_o=1 for one cycle, then -> IDLE.
- Requantize, per entry, with value v signed:
  - If shift>0, r = (v + 2^(shift-1)) >>> shift. The add is done in OUTPUT_BUF_SIZE+1 bits, so there is no wrap. If shift=0, r = v.
  - Saturate r to [-128, 127].
  - If relu_en, a negative result becomes 0.
- Packing:
  - A non-zero result sets sparsemap bit[lane].
  - It is written to enc_nonzero_data_o[ptr], then ptr increments.
  - Slots at or above the final ptr are 0.
  - Non-zero values appear in ascending lane order.
- enc_wr_count_o = group index for the beat being presented.
- start_i is ignored in READ, EMIT and DONE.
- Reset values: busy_o, done_o, enc_wr_valid_o, out_buf_sel_o, enc_wr_count_o, enc_sparsemap_o and enc_nonzero_data_o are all 0. State is IDLE.
- out_buf_sel_o is 0 whenever it is not in READ.

## Timing
- Accepted start at edge N: first READ cycle is N+1, presenting sel=0.
- READ takes BUS_SIZE cycles per group. enc_wr_valid_o rises the cycle after the last READ cycle.
- With enc_ready_i held high, each beat takes BUS_SIZE+1 cycles. Defaults: 36 cycles from start to the last handshake, done_o in cycle 37.
- While valid && !ready: sparsemap, data, count and valid stay stable. No read advances.
- Valid drops the cycle after the handshake, except that it stays low through the next group's READ.
- rst_i low in any state: all outputs reach reset values at the next edge. No partial beat is emitted after reset.
- shift_i and relu_en_i changes mid-drain have no effect.

## Test plan
- All 32 entries 0, shift 0, ready high -> 4 beats, sparsemap 0x00, data all 0, counts 0,1,2,3; done_o in cycle 37; busy_o low in the done_o cycle.
- Entries 0..7 = {5,0,-3,0,0,0,0,9}, shift 0, relu off -> beat 0 sparsemap 0x85, data[0..2] = {0x05, 0xFD, 0x09}, data[3..7] = 0.
- Entries {1000, 6, -6, -1000, 2, 1, -2, 0}, shift 2 -> results {127, 2, -1, -128, 1, 0, 0, 0}; sparsemap 0x1F.
- Same entries, shift 2, relu on -> {127, 2, 0, 0, 1, 0, 0, 0}; sparsemap 0x13; data {127, 2, 1, 0...}.
- enc_ready_i low for 5 cycles during beat 1 -> beat 1 outputs stable; out_buf_sel_o 0; done_o delayed to cycle 42.
- start_i pulsed during READ is ignored. rst_i low during beat 2 READ -> all outputs 0 at the next edge. A new start afterwards drains from count 0.
